// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit, one bit per cycle; define MULDIV_FAST_MUL_EN for single-cycle multiply
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state, state_nx;
   logic [2:0]      op_q;
   logic [XLEN:0]   hi_q, hi_nx;
   logic [XLEN-1:0] lo_q, lo_nx, b_q;
   logic            neg_q;
   logic [CW-1:0]   cnt_q;
   logic            res_load;
   logic [XLEN-1:0] res_nx;

   // Decode of the request presented at the inputs (only meaningful on acceptance)
   logic            accept, div_zero, div_ovf, sgn1, sgn2, neg1, neg2, neg_acc, fast_mul;
   logic [XLEN-1:0] mag1, mag2, spec_res, fast_res;

   assign accept   = (state == S_IDLE) && start && !flush;
   assign div_zero = op[2] && (rs2_data == '0);
   assign div_ovf  = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
   assign sgn1     = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
   assign sgn2     = (op == 3'b001) || (op[2] && !op[0]);
   assign neg1     = sgn1 && rs1_data[XLEN-1];
   assign neg2     = sgn2 && rs2_data[XLEN-1];
   assign mag1     = neg1 ? -rs1_data : rs1_data;
   assign mag2     = neg2 ? -rs2_data : rs2_data;
   // Remainder takes the dividend's sign; everything else the xor of operand signs
   assign neg_acc  = (op == 3'b110) ? neg1 : (neg1 ^ neg2);
   // Divide by zero: quotient all ones, remainder is the dividend; overflow: quotient dividend, remainder 0
   assign spec_res = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] ext1, ext2, fast_prod;
   assign ext1      = {{XLEN{neg1}}, rs1_data};
   assign ext2      = {{XLEN{neg2}}, rs2_data};
   assign fast_prod = ext1 * ext2;
   assign fast_mul  = !op[2];
   assign fast_res  = (op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
   assign fast_mul  = 1'b0;
   assign fast_res  = '0;
`endif

   // One iteration: shift-add multiply step or restoring divide step
   logic [XLEN:0] mul_sum, div_shift, div_diff;
   always_comb begin
      mul_sum   = lo_q[0] ? (hi_q + {1'b0, b_q}) : hi_q;
      div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_nx = div_diff;
            lo_nx = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_nx = div_shift;
            lo_nx = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nx = {1'b0, mul_sum[XLEN:1]};
         lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction and result selection from the final iteration's values
   logic [2*XLEN-1:0] prod_raw, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;
   always_comb begin
      prod_raw = {hi_nx[XLEN-1:0], lo_nx};
      prod_fix = neg_q ? -prod_raw : prod_raw;
      quo_fix  = neg_q ? -lo_nx : lo_nx;
      rem_fix  = neg_q ? -hi_nx[XLEN-1:0] : hi_nx[XLEN-1:0];
      case (op_q)
         3'b000:          calc_res = prod_fix[XLEN-1:0];
         3'b100, 3'b101:  calc_res = quo_fix;
         3'b110, 3'b111:  calc_res = rem_fix;
         default:         calc_res = prod_fix[2*XLEN-1:XLEN];
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and result-load decision; flush beats start and completion
   always_comb begin
      state_nx = state;
      res_load = 1'b0;
      res_nx   = calc_res;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (div_zero || div_ovf) begin
                  state_nx = S_DONE;
                  res_load = 1'b1;
                  res_nx   = spec_res;
               end else if (fast_mul) begin
                  state_nx = S_DONE;
                  res_load = 1'b1;
                  res_nx   = fast_res;
               end else begin
                  state_nx = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_nx = S_IDLE;
            end else if (cnt_q == CW'(XLEN-1)) begin
               state_nx = S_DONE;
               res_load = 1'b1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Operand capture on acceptance, iteration in CALC, result load on entry to DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            op_q  <= op;
            hi_q  <= '0;
            lo_q  <= mag1;
            b_q   <= mag2;
            neg_q <= neg_acc;
            cnt_q <= '0;
         end else if (state == S_CALC) begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + CW'(1);
         end
         if (res_load && !reset) result <= res_nx;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (XLEN=32) against an arithmetic reference model
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 0) return 1;
      if (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!o[2]) return 1;
`endif
      return 33;
   endfunction

   // Accept in cycle 0, return result and the cycle number of done (-1 if none within budget)
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic scramble, output logic [31:0] res, output int lat);
      op = o; rs1_data = a; rs2_data = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (scramble) begin
            op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; flush = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; start = 1'b0; flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", result); end
   endtask

   logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

   task automatic test_directed();
      logic [31:0] res;
      int          lat, e_lat;
      for (int i = 0; i < 12; i++) begin
         e_lat = ref_latency(d_op[i], d_a[i], d_b[i]);
         run_op(d_op[i], d_a[i], d_b[i], 1'b1, res, lat);
         n_cmp++;
         if (res !== d_exp[i]) begin
            n_err++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_exp[i]);
         end
         n_cmp++;
         if (lat !== e_lat) begin
            n_err++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, e_lat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, held;
      logic [2:0]  o;
      int          sel, lat, e_lat;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         e_lat = ref_latency(o, a, b);
         run_op(o, a, b, 1'b1, res, lat);
         n_cmp++;
         if (res !== ref_result(o, a, b)) begin
            n_err++; $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, res, ref_result(o, a, b));
         end
         n_cmp++;
         if (lat !== e_lat) begin
            n_err++; $display("FAIL random_latency op=%0d: got %0d expected %0d", o, lat, e_lat);
         end
         held = res;
         @(posedge clk); #1;
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== held) begin
            n_err++; $display("FAIL random_after_done: got done=%b busy=%b result=%h expected 0 0 %h", done, busy, result, held);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int          lat;
      run_op(3'd5, 32'd1000, 32'd10, 1'b0, res, lat);
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b expected 0", busy); end
      run_op(3'd7, 32'd1000, 32'd9, 1'b0, res, lat);
      n_cmp++; if (res !== 32'd1) begin n_err++; $display("FAIL b2b_result: got %h expected 00000001", res); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_start_held();
      int cyc;
      op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      while (!done && cyc < 100) begin
         op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      n_cmp++; if (result !== 32'd333) begin n_err++; $display("FAIL held_result: got %h expected 0000014d", result); end
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL held_latency: got %0d expected 33", cyc); end
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (busy || done) cyc++;
      end
      n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL held_second_request: got %0d busy/done cycles expected 0", cyc); end
   endtask

   task automatic test_flush();
      logic [31:0] prev, res;
      int          seen, lat;
      run_op(3'd7, 32'd100, 32'd7, 1'b0, res, lat);
      @(posedge clk); #1;
      prev = result;
      op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      for (int i = 1; i < 10; i++) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0 || seen !== 0) begin n_err++; $display("FAIL flush_done: got %b/%0d expected 0/0", done, seen); end
      n_cmp++; if (result !== prev) begin n_err++; $display("FAIL flush_result: got %h expected %h", result, prev); end
      run_op(3'd4, 32'hFFFF_FC18, 32'd7, 1'b0, res, lat);
      n_cmp++; if (res !== 32'hFFFF_FF72) begin n_err++; $display("FAIL flush_restart_result: got %h expected ffffff72", res); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL flush_restart_latency: got %0d expected 33", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_start();
      int seen;
      op = 3'd5; rs1_data = 32'd50; rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy || done) seen++;
         @(posedge clk); #1;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_over_start: got %0d busy/done cycles expected 0", seen); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      int          lat, seen;
      run_op(3'd5, 32'd100, 32'd7, 1'b0, res, lat);
      @(posedge clk); #1;
      op = 3'd4; rs1_data = 32'd12345; rs2_data = 32'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL midreset_result: got %h expected 00000000", result); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midreset_late_done: got %0d pulses expected 0", seen); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      op = 3'd0; rs1_data = '0; rs2_data = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_held();
      test_flush();
      test_flush_start();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
